// File: rtl/spi_byte_slave_pkg.sv
// Shared constants for the CSR-over-SPI front end.
// Idle transmit byte, synchroniser depth, CSR command bit layout.
package spi_byte_slave_pkg;

   localparam logic [7:0]  SPI_IDLE_BYTE   = 8'h00;
   localparam int unsigned SPI_SYNC_STAGES = 2;

   // CSR command byte: bit7 = write, [3:0] = address high nibble
   localparam int unsigned CSR_CMD_WRITE_BIT = 7;
   localparam int unsigned CSR_CMD_ADDR_MSB  = 3;
   localparam int unsigned CSR_CMD_ADDR_LSB  = 0;

   function automatic logic [7:0] shl_in(input logic [7:0] r,
                                         input logic b);
      return {r[6:0], b};
   endfunction

endpackage

// File: rtl/spi_byte_slave_sync_ff.sv
// sync_ff: single-bit synchroniser of STAGES flops, reset to RST_VAL.
// Ports: clk, rst (sync, active high), d (async in), q (synced out).
module sync_ff #(
   parameter int unsigned STAGES  = 2,
   parameter logic        RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] r;

   always_ff @(posedge clk) begin
      if (rst) r <= {STAGES{RST_VAL}};
      else     r <= {r[STAGES-2:0], d};
   end

   assign q = r[STAGES-1];

endmodule

// File: rtl/spi_byte_slave.sv
// SPI mode-0 slave byte transceiver, oversampled in the clk domain.
// Ports: clk/rst, sck/mosi/ss/miso (SPI), rst_o session reset,
// data_o/ack_pop_o rx byte pop, data_i/ack_i next tx byte.
module spi_byte_slave
   import spi_byte_slave_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = SPI_SYNC_STAGES,
   parameter logic [7:0]  IDLE_TX     = SPI_IDLE_BYTE
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       sck,
   output logic       miso,
   input  logic       mosi,
   input  logic       ss,
   output logic       rst_o,
   output logic [7:0] data_o,
   output logic       ack_pop_o,
   input  logic [7:0] data_i,
   input  logic       ack_i
);

   logic       sck_s, mosi_s, ss_s;
   logic       sck_d, ss_d;
   logic       rise, fall, boundary;
   logic [2:0] bit_cnt;
   logic [7:0] rx_shift, tx_shift, tx_buf;
   logic       tx_valid;

   sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sck (
      .clk(clk), .rst(rst), .d(sck), .q(sck_s)
   );
   sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi (
      .clk(clk), .rst(rst), .d(mosi), .q(mosi_s)
   );
   // ss resets deasserted so a reset always starts a fresh session
   sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ss (
      .clk(clk), .rst(rst), .d(ss), .q(ss_s)
   );

   assign rise     = sck_s & ~sck_d & ~ss_s;
   assign fall     = ~sck_s & sck_d & ~ss_s;
   assign boundary = fall & (bit_cnt == 3'd0);
   assign miso     = tx_shift[7] & ~ss_s;

   always_ff @(posedge clk) begin
      if (rst) begin
         sck_d     <= 1'b0;
         ss_d      <= 1'b1;
         rst_o     <= 1'b1;
         data_o    <= 8'h00;
         ack_pop_o <= 1'b0;
         bit_cnt   <= 3'd0;
         rx_shift  <= 8'h00;
         tx_shift  <= 8'h00;
         tx_buf    <= 8'h00;
         tx_valid  <= 1'b0;
      end else begin
         sck_d     <= sck_s;
         ss_d      <= ss_s;
         rst_o     <= ss_s;
         ack_pop_o <= 1'b0;
         if (ss_s) begin
            bit_cnt  <= 3'd0;
            rx_shift <= 8'h00;
            tx_valid <= 1'b0;
            tx_shift <= IDLE_TX;
         end else begin
            if (ss_d)
               tx_shift <= IDLE_TX;
            if (rise) begin
               rx_shift <= shl_in(rx_shift, mosi_s);
               bit_cnt  <= bit_cnt + 3'd1;
               if (bit_cnt == 3'd7) begin
                  data_o    <= shl_in(rx_shift, mosi_s);
                  ack_pop_o <= 1'b1;
               end
            end
            if (ack_i)
               tx_buf <= data_i;
            // an ack landing on the boundary goes straight out
            if (boundary) begin
               if (ack_i)         tx_shift <= data_i;
               else if (tx_valid) tx_shift <= tx_buf;
               else               tx_shift <= IDLE_TX;
               tx_valid <= 1'b0;
            end else begin
               if (fall)
                  tx_shift <= shl_in(tx_shift, 1'b0);
               if (ack_i)
                  tx_valid <= 1'b1;
            end
         end
      end
   end

endmodule
